// File: rtl/tc_mode_counter.sv
// rtl/tc_mode_counter.sv - loadable bidirectional step counter with wrap/sat/oneshot/free modes
module tc_mode_counter #(
  parameter int BIT_WIDTH  = 8,
  parameter int STEP_WIDTH = 8
) (
  input  logic                  clk,
  input  logic                  rst,
  input  logic                  en,
  input  logic                  load,
  input  logic [BIT_WIDTH-1:0]  load_val,
  input  logic                  dir,
  input  logic [STEP_WIDTH-1:0] step,
  input  logic [BIT_WIDTH-1:0]  limit,
  input  logic [1:0]            mode,
  output logic [BIT_WIDTH-1:0]  out,
  output logic                  tc,
  output logic                  done
);

  typedef enum logic [1:0] {
    MODE_WRAP    = 2'd0,
    MODE_SAT     = 2'd1,
    MODE_ONESHOT = 2'd2,
    MODE_FREE    = 2'd3
  } mode_e;

  // One extra bit on every operand so carry and borrow fall out of the arithmetic.
  logic [BIT_WIDTH:0]   out_x;
  logic [BIT_WIDTH:0]   step_x;
  logic [BIT_WIDTH:0]   lim_x;
  logic [BIT_WIDTH:0]   sum;
  logic [BIT_WIDTH:0]   diff;
  logic [BIT_WIDTH-1:0] out_nxt;
  logic                 tc_nxt;
  logic                 done_nxt;
  mode_e                mode_q;

  assign out_x  = {1'b0, out};
  assign step_x = {{(BIT_WIDTH + 1 - STEP_WIDTH){1'b0}}, step};
  assign lim_x  = {1'b0, limit};
  assign sum    = out_x + step_x;
  assign diff   = out_x - step_x;
  assign mode_q = mode_e'(mode);

  // Next count, terminal-count pulse and done flag; tc defaults low so idle edges clear it.
  always_comb begin
    out_nxt  = out;
    tc_nxt   = 1'b0;
    done_nxt = done;
    if (load) begin
      out_nxt  = load_val;
      done_nxt = 1'b0;
    end else if (en && !done && (step_x != '0)) begin
      case (mode_q)
        MODE_WRAP: begin
          if (!dir) begin
            if (sum > lim_x) begin
              out_nxt = '0;
              tc_nxt  = 1'b1;
            end else begin
              out_nxt = sum[BIT_WIDTH-1:0];
            end
          end else begin
            if (out_x < step_x) begin
              out_nxt = limit;
              tc_nxt  = 1'b1;
            end else begin
              out_nxt = diff[BIT_WIDTH-1:0];
            end
          end
        end
        MODE_SAT, MODE_ONESHOT: begin
          if (!dir) begin
            if (sum >= lim_x) begin
              out_nxt  = limit;
              tc_nxt   = 1'b1;
              done_nxt = (mode_q == MODE_ONESHOT);
            end else begin
              out_nxt = sum[BIT_WIDTH-1:0];
            end
          end else begin
            if (out_x <= step_x) begin
              out_nxt  = '0;
              tc_nxt   = 1'b1;
              done_nxt = (mode_q == MODE_ONESHOT);
            end else begin
              out_nxt = diff[BIT_WIDTH-1:0];
            end
          end
        end
        default: begin
          if (!dir) begin
            out_nxt = sum[BIT_WIDTH-1:0];
            tc_nxt  = sum[BIT_WIDTH];
          end else begin
            out_nxt = diff[BIT_WIDTH-1:0];
            tc_nxt  = diff[BIT_WIDTH];
          end
        end
      endcase
    end
  end

  // State register on the falling edge; reset beats every other input.
  always_ff @(negedge clk) begin
    if (rst) begin
      out  <= '0;
      tc   <= 1'b0;
      done <= 1'b0;
    end else begin
      out  <= out_nxt;
      tc   <= tc_nxt;
      done <= done_nxt;
    end
  end

endmodule

// File: tb/tb_tc_mode_counter.sv
// tb/tb_tc_mode_counter.sv - table, directed and randomized checks of tc_mode_counter
module tb_tc_mode_counter;

  localparam int BW  = 8;
  localparam int SW  = 8;
  localparam int MAXV = 1 << BW;

  logic          clk;
  logic          rst;
  logic          en;
  logic          load;
  logic [BW-1:0] load_val;
  logic          dir;
  logic [SW-1:0] step;
  logic [BW-1:0] limit;
  logic [1:0]    mode;
  logic [BW-1:0] out;
  logic          tc;
  logic          done;

  tc_mode_counter #(.BIT_WIDTH(BW), .STEP_WIDTH(SW)) dut (
    .clk(clk), .rst(rst), .en(en), .load(load), .load_val(load_val),
    .dir(dir), .step(step), .limit(limit), .mode(mode),
    .out(out), .tc(tc), .done(done)
  );

  initial begin
    clk = 1'b1;
    forever #5 clk = ~clk;
  end

  typedef struct {
    int r; int ld; int lv; int e; int d; int st; int lim; int md;
    int x_out; int x_tc; int x_done;
  } vec_t;

  vec_t vecs[64];
  int   nvec;
  int   n_pass;
  int   n_total;

  // Reference model state, plain integers
  int m_out, m_tc, m_done;

  task automatic add(input int r, input int ld, input int lv, input int e, input int d,
                     input int st, input int lim, input int md,
                     input int xo, input int xt, input int xd);
    vecs[nvec] = '{r, ld, lv, e, d, st, lim, md, xo, xt, xd};
    nvec++;
  endtask

  task automatic check(input string name, input int act, input int exp);
    n_total++;
    if (act == exp) n_pass++;
    else $display("FAIL %s: got %0d expected %0d", name, act, exp);
  endtask

  task automatic model_edge();
    int s;
    if (rst) begin
      m_out = 0; m_tc = 0; m_done = 0;
    end else if (load) begin
      m_out = int'(load_val); m_tc = 0; m_done = 0;
    end else if (en && m_done == 0 && step != 0) begin
      s = int'(step);
      m_tc = 0;
      if (mode == 2'd0) begin
        if (!dir) begin
          if (m_out + s > int'(limit)) begin m_out = 0; m_tc = 1; end
          else m_out = m_out + s;
        end else begin
          if (m_out < s) begin m_out = int'(limit); m_tc = 1; end
          else m_out = m_out - s;
        end
      end else if (mode == 2'd3) begin
        if (!dir) begin
          m_tc  = (m_out + s >= MAXV) ? 1 : 0;
          m_out = (m_out + s) % MAXV;
        end else begin
          m_tc  = (m_out < s) ? 1 : 0;
          m_out = (m_out - s + MAXV) % MAXV;
        end
      end else begin
        if (!dir && m_out + s >= int'(limit)) begin
          m_out = int'(limit); m_tc = 1;
        end else if (dir && m_out <= s) begin
          m_out = 0; m_tc = 1;
        end else begin
          m_out = dir ? m_out - s : m_out + s;
        end
        if (m_tc == 1 && mode == 2'd2) m_done = 1;
      end
    end else begin
      m_tc = 0;
    end
  endtask

  task automatic drive(input int r, input int ld, input int lv, input int e, input int d,
                       input int st, input int lim, input int md);
    rst = r[0]; load = ld[0]; load_val = lv[BW-1:0]; en = e[0]; dir = d[0];
    step = st[SW-1:0]; limit = lim[BW-1:0]; mode = md[1:0];
  endtask

  task automatic tick();
    model_edge();
    @(negedge clk);
    #1;
  endtask

  task automatic expect3(input string name, input int xo, input int xt, input int xd);
    check({name, ".out"}, int'(out), xo);
    check({name, ".tc"}, int'(tc), xt);
    check({name, ".done"}, int'(done), xd);
  endtask

  initial begin
    n_pass = 0; n_total = 0; nvec = 0;
    m_out = 0; m_tc = 0; m_done = 0;
    drive(1, 0, 0, 0, 0, 0, 0, 0);

    //   r ld  lv e d  st lim md  out tc done
    add(1, 0,   0, 0, 0, 0,   0, 0,   0, 0, 0);
    add(0, 0,   0, 1, 0, 2,   5, 0,   2, 0, 0);
    add(0, 0,   0, 1, 0, 2,   5, 0,   4, 0, 0);
    add(0, 0,   0, 1, 0, 2,   5, 0,   0, 1, 0);
    add(0, 0,   0, 1, 0, 2,   5, 0,   2, 0, 0);
    add(0, 0,   0, 1, 0, 2,   5, 0,   4, 0, 0);
    add(0, 1,   3, 0, 1, 2,   9, 0,   3, 0, 0);
    add(0, 0,   0, 1, 1, 2,   9, 0,   1, 0, 0);
    add(0, 0,   0, 1, 1, 2,   9, 0,   9, 1, 0);
    add(0, 0,   0, 1, 1, 2,   9, 0,   7, 0, 0);
    add(0, 0,   0, 1, 1, 2,   9, 0,   5, 0, 0);
    add(0, 1, 250, 0, 0, 4, 255, 1, 250, 0, 0);
    add(0, 0,   0, 1, 0, 4, 255, 1, 254, 0, 0);
    add(0, 0,   0, 1, 0, 4, 255, 1, 255, 1, 0);
    add(0, 0,   0, 1, 0, 4, 255, 1, 255, 1, 0);
    add(0, 0,   0, 1, 1, 255, 255, 1, 0, 1, 0);
    add(0, 1,   0, 0, 0, 1,   3, 2,   0, 0, 0);
    add(0, 0,   0, 1, 0, 1,   3, 2,   1, 0, 0);
    add(0, 0,   0, 1, 0, 1,   3, 2,   2, 0, 0);
    add(0, 0,   0, 1, 0, 1,   3, 2,   3, 1, 1);
    for (int i = 0; i < 4; i++)
      add(0, 0, 0, 1, 0, 1,   3, 2,   3, 0, 1);
    add(0, 1,   0, 0, 0, 1,   3, 2,   0, 0, 0);
    add(0, 1, 254, 0, 0, 3,   0, 3, 254, 0, 0);
    add(0, 0,   0, 1, 0, 3,   0, 3,   1, 1, 0);
    add(1, 1,   7, 1, 0, 3,   0, 3,   0, 0, 0);
    add(0, 1,   7, 1, 0, 3,   0, 3,   7, 0, 0);
    add(0, 0,   0, 1, 0, 0,   0, 3,   7, 0, 0);
    add(0, 0,   0, 1, 0, 0,   9, 0,   7, 0, 0);
    add(0, 0,   0, 1, 0, 1,   0, 0,   0, 1, 0);
    add(0, 0,   0, 1, 0, 1,   0, 0,   0, 1, 0);
    add(0, 1,   0, 0, 0, 1,   3, 2,   0, 0, 0);
    add(0, 0,   0, 1, 0, 1,   3, 2,   1, 0, 0);
    add(0, 0,   0, 1, 0, 1,   3, 2,   2, 0, 0);
    add(0, 0,   0, 1, 0, 1,   3, 2,   3, 1, 1);
    add(1, 0,   0, 1, 0, 1,   3, 2,   0, 0, 0);

    #2;
    for (int i = 0; i < nvec; i++) begin
      drive(vecs[i].r, vecs[i].ld, vecs[i].lv, vecs[i].e, vecs[i].d,
            vecs[i].st, vecs[i].lim, vecs[i].md);
      tick();
      expect3($sformatf("vec%0d", i), vecs[i].x_out, vecs[i].x_tc, vecs[i].x_done);
    end

    // Out-of-range start: WRAP up wraps to 0, SAT up clamps to limit
    drive(0, 1, 200, 0, 0, 1, 50, 0); tick();
    drive(0, 0, 0, 1, 0, 1, 50, 0);   tick();
    expect3("wrap_oor", 0, 1, 0);
    drive(0, 1, 200, 0, 0, 1, 50, 1); tick();
    drive(0, 0, 0, 1, 0, 1, 50, 1);   tick();
    expect3("sat_oor", 50, 1, 0);

    // ONESHOT down reaching 0 sets done; later mode change leaves done set
    drive(0, 1, 5, 0, 1, 3, 0, 2); tick();
    drive(0, 0, 0, 1, 1, 3, 0, 2); tick();
    expect3("os_dn1", 2, 0, 0);
    tick();
    expect3("os_dn2", 0, 1, 1);
    drive(0, 0, 0, 1, 0, 3, 0, 3); tick();
    expect3("os_modechg", 0, 0, 1);

    // Randomized run against the reference model
    for (int i = 0; i < 600; i++) begin
      drive(($urandom_range(0, 49) == 0) ? 1 : 0,
            ($urandom_range(0, 11) == 0) ? 1 : 0,
            int'($urandom_range(0, MAXV - 1)),
            ($urandom_range(0, 4) != 0) ? 1 : 0,
            int'($urandom_range(0, 1)),
            ($urandom_range(0, 2) == 0) ? int'($urandom_range(0, MAXV - 1)) : int'($urandom_range(0, 4)),
            ($urandom_range(0, 7) == 0) ? 0 : int'($urandom_range(0, MAXV - 1)),
            int'($urandom_range(0, 3)));
      tick();
      expect3($sformatf("rnd%0d", i), m_out, m_tc, m_done);
    end

    $display("%0d/%0d checks passed", n_pass, n_total);
    $finish;
  end

endmodule
